sprite_fetch: RTL and testbench
===============================

# sprite_fetch

Sprite fetch sequencer on the video side of the sprite engine's tile-data port. Once per visible line it:
- pulses `sort` to start sprite priority sorting;
- waits for the sort to settle;
- walks `index` through the 10 leftmost sprite slots;
- reads the two bit-plane bytes of each selected sprite row from VRAM over a req/ack handshake;
- hands each byte back with a one-cycle `dvalid` strobe.

It sits between the LCD timing controller, the sprite engine and the VRAM arbiter.

## Interface
Parameters:
- `SPR_PER_LINE`, 10, number of sprite slots fetched per line.
- `SORT_CYCLES`, 40, cycles waited after `sort` before the first fetch.

Ports:
- `clk`  in  1  core clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `line_start`  in  1  one-cycle pulse at the start of the OAM phase of a visible line.
- `abort`  in  1  one-cycle pulse for LCD off or end of the line window; cancels the fetch.
- `sort`  out  1  one-cycle pulse that loads the sprite sorter.
- `index`  out  4  sprite slot being serviced, 0..SPR_PER_LINE-1.
- `addr`  in  11  row address returned by the sprite engine for `index`; byte address = {tile, row}.
- `vram_req`  out  1  VRAM read request.
- `vram_addr`  out  12  VRAM byte address, {addr, plane}; plane 0 = low byte, 1 = high byte.
- `vram_ack`  in  1  read accepted; `vram_data`/`vram_data1` are valid in this cycle.
- `vram_data`  in  8  byte from VRAM bank 0.
- `vram_data1`  in  8  byte from VRAM bank 1 (GBC).
- `dvalid`  out  2  bit 0 strobes the low plane, bit 1 strobes the high plane; one-hot or zero.
- `data`  out  8  registered bank-0 byte.
- `data1`  out  8  registered bank-1 byte.
- `busy`  out  1  high from the `sort` cycle until the fetch completes or is aborted.
- `done`  out  1  one-cycle pulse after the last slot's high-plane strobe.

## Operation
- FSM states: IDLE, SORT_WAIT, SETUP, REQ_LO, DV_LO, REQ_HI, DV_HI, DONE.
- IDLE:
  - `line_start` -> SORT_WAIT.
  - Also `sort`=1 and `busy`=1 in the next cycle.
  - Wait counter cleared; `index` cleared.
- SORT_WAIT: counts SORT_CYCLES cycles, including the `sort` cycle, then -> SETUP.
- SETUP:
  - Lasts one cycle; `index` is stable so the sprite engine's `addr` can settle.
  - `addr` is captured into an internal register at the end of SETUP.
- REQ_LO:
  - `vram_req`=1 and `vram_addr`={addr_q,1'b0}, held until `vram_ack`.
  - On ack, `vram_data`/`vram_data1` are registered into `data`/`data1`, then -> DV_LO.
- DV_LO: `dvalid`=2'b01 for exactly one cycle, then -> REQ_HI.
- REQ_HI: as REQ_LO, with plane bit = 1.
- DV_HI:
  - `dvalid`=2'b10 for one cycle.
  - If `index`==SPR_PER_LINE-1 -> DONE; otherwise `index`+1 and -> SETUP.
- DONE: `done`=1 and `busy`=0 for one cycle, then -> IDLE.
- `index` holds its value from SETUP through DV_HI, so the sprite engine's per-slot data select stays valid during both strobes.
- `data`/`data1` keep their last value outside the strobe cycles.
- `abort` (any state):
  - Next state is IDLE.
  - `vram_req`, `dvalid`, `busy` and `sort` are all 0 in the next cycle.
  - No `done` pulse.
  - Abort has priority over a simultaneous `line_start`; that `line_start` is ignored.
- `line_start` while busy and not aborted: restart.
  - `sort` pulses again; counter and `index` return to 0.
  - An outstanding `vram_req` is dropped; a pending ack is ignored.
- `vram_ack` outside REQ_LO/REQ_HI is ignored.

## Timing
- Reset values: state IDLE, all outputs 0 (`sort`, `index`, `vram_req`, `vram_addr`, `dvalid`, `data`, `data1`, `busy`, `done`).
- All outputs are registered.
- `line_start` at cycle 0 -> `sort` at cycle 1.
- First SETUP at cycle 1+SORT_CYCLES.
- Per slot with zero-wait ack: 5 cycles (SETUP, REQ_LO, DV_LO, REQ_HI, DV_HI). Each VRAM wait cycle adds 1.
- Zero-wait full line: `done` at cycle 1+SORT_CYCLES+5*SPR_PER_LINE = 91 with defaults.
- Strobe timing:
  - `dvalid[0]` occurs the cycle after the low-plane ack.
  - `dvalid[1]` occurs the cycle after the high-plane ack.
- `index` increments on the cycle after DV_HI.

## Structure
- Shared package `sprite_fetch_pkg` holds:
  - the FSM state enum;
  - `SPR_PER_LINE_DEFAULT` and `SORT_CYCLES_DEFAULT`;
  - `TILE_ADDR_W`=11 and `VRAM_ADDR_W`=12.
- No sub-module; counter, FSM and data registers are inline.

## Test plan
- Zero-wait fetch:
  - Stimulus: `line_start`; `addr`=11'h155 for every slot; ack on first req; `vram_data`=8'hA5/8'h5A for the low/high planes.
  - Response: `sort` at cycle 1; first `vram_addr`=12'h2AA then 12'h2AB; `dvalid` 01 with `data`=A5, then 10 with `data`=5A; 10 slots; `done` at cycle 91.
- Wait states:
  - Stimulus: ack delayed 3 cycles on every request.
  - Response: `vram_req` held steady; each slot takes 11 cycles; `done` at cycle 151.
- Index stability:
  - Stimulus: `addr`=index*16; monitor `index`.
  - Response: `index` unchanged from SETUP through DV_HI; `vram_addr` high bits track index*16.
- Abort:
  - Stimulus: `abort` while in REQ_HI of slot 4.
  - Response: next cycle `vram_req`=0, `busy`=0, `dvalid`=0; no `done`; a later ack is ignored.
- Restart and collision:
  - Stimulus 1: `line_start` while in SORT_WAIT.
  - Response 1: second `sort` pulse; counter restarts; `done` at 91 cycles after the second `line_start`.
  - Stimulus 2: `abort` and `line_start` in the same cycle.
  - Response 2: FSM goes to IDLE; no `sort` pulse.
- Reset:
  - Stimulus: `reset` asserted in DV_LO.
  - Response: next cycle all outputs 0 and FSM in IDLE.

Source files
------------

// File: rtl/sprite_fetch_pkg.sv
// rtl/sprite_fetch_pkg.sv - shared types and widths for the sprite fetch sequencer
package sprite_fetch_pkg;

    localparam int SPR_PER_LINE_DEFAULT = 10;
    localparam int SORT_CYCLES_DEFAULT  = 40;
    localparam int TILE_ADDR_W          = 11;
    localparam int VRAM_ADDR_W          = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SORT_WAIT,
        ST_SETUP,
        ST_REQ_LO,
        ST_DV_LO,
        ST_REQ_HI,
        ST_DV_HI,
        ST_DONE
    } fetch_state_t;

endpackage

// File: rtl/sprite_fetch.sv
// rtl/sprite_fetch.sv - per-line sprite sort kick-off and two-plane VRAM tile fetch
module sprite_fetch
    import sprite_fetch_pkg::*;
#(
    parameter int SPR_PER_LINE = SPR_PER_LINE_DEFAULT,
    parameter int SORT_CYCLES  = SORT_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   line_start,
    input  logic                   abort,
    output logic                   sort,
    output logic [3:0]             index,
    input  logic [TILE_ADDR_W-1:0] addr,
    output logic                   vram_req,
    output logic [VRAM_ADDR_W-1:0] vram_addr,
    input  logic                   vram_ack,
    input  logic [7:0]             vram_data,
    input  logic [7:0]             vram_data1,
    output logic [1:0]             dvalid,
    output logic [7:0]             data,
    output logic [7:0]             data1,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W = $clog2(SORT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SORT_CYCLES - 1);
    localparam logic [3:0]       IDX_LAST = 4'(SPR_PER_LINE - 1);

    fetch_state_t               state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [3:0]                 index_q, index_d;
    logic [TILE_ADDR_W-1:0]     addr_q, addr_d;
    logic [7:0]                 data_q, data_d;
    logic [7:0]                 data1_q, data1_d;
    logic                       sort_q, sort_d;
    logic                       vram_req_q, vram_req_d;
    logic [VRAM_ADDR_W-1:0]     vram_addr_q, vram_addr_d;
    logic [1:0]                 dvalid_q, dvalid_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       start;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        index_d = index_q;
        addr_d  = addr_q;
        data_d  = data_q;
        data1_d = data1_q;
        start   = 1'b0;

        // Abort outranks line_start; line_start from any other state restarts the line.
        if (abort) begin
            state_d = ST_IDLE;
        end else if (line_start) begin
            state_d = ST_SORT_WAIT;
            start   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_SORT_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_SETUP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SETUP: begin
                    addr_d  = addr;
                    state_d = ST_REQ_LO;
                end
                ST_REQ_LO: begin
                    if (vram_ack) begin
                        data_d  = vram_data;
                        data1_d = vram_data1;
                        state_d = ST_DV_LO;
                    end
                end
                ST_DV_LO: state_d = ST_REQ_HI;
                ST_REQ_HI: begin
                    if (vram_ack) begin
                        data_d  = vram_data;
                        data1_d = vram_data1;
                        state_d = ST_DV_HI;
                    end
                end
                ST_DV_HI: begin
                    if (index_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = ST_SETUP;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        if (start || state_d == ST_IDLE) begin
            cnt_d   = '0;
            index_d = '0;
        end
    end

    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        sort_d      = start;
        vram_req_d  = (state_d == ST_REQ_LO) || (state_d == ST_REQ_HI);
        vram_addr_d = vram_addr_q;
        if (state_d == ST_REQ_LO) begin
            vram_addr_d = {addr_d, 1'b0};
        end else if (state_d == ST_REQ_HI) begin
            vram_addr_d = {addr_q, 1'b1};
        end
        dvalid_d = 2'b00;
        if (state_d == ST_DV_LO) begin
            dvalid_d = 2'b01;
        end else if (state_d == ST_DV_HI) begin
            dvalid_d = 2'b10;
        end
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            index_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            data1_q     <= '0;
            sort_q      <= 1'b0;
            vram_req_q  <= 1'b0;
            vram_addr_q <= '0;
            dvalid_q    <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            index_q     <= index_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            data1_q     <= data1_d;
            sort_q      <= sort_d;
            vram_req_q  <= vram_req_d;
            vram_addr_q <= vram_addr_d;
            dvalid_q    <= dvalid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sort      = sort_q;
    assign index     = index_q;
    assign vram_req  = vram_req_q;
    assign vram_addr = vram_addr_q;
    assign dvalid    = dvalid_q;
    assign data      = data_q;
    assign data1     = data1_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// tb/tb_sprite_fetch.sv - directed self-checking bench for sprite_fetch
module tb_sprite_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic        abort = 1'b0;
    logic        sort;
    logic [3:0]  index;
    logic [10:0] addr = 11'h155;
    logic        vram_req;
    logic [11:0] vram_addr;
    logic        vram_ack = 1'b0;
    logic [7:0]  vram_data = 8'h00;
    logic [7:0]  vram_data1 = 8'h00;
    logic [1:0]  dvalid;
    logic [7:0]  data;
    logic [7:0]  data1;
    logic        busy;
    logic        done;

    sprite_fetch dut (
        .clk(clk), .reset(reset), .line_start(line_start), .abort(abort),
        .sort(sort), .index(index), .addr(addr),
        .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack),
        .vram_data(vram_data), .vram_data1(vram_data1),
        .dvalid(dvalid), .data(data), .data1(data1), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc, ack_delay, wait_cnt, addr_mode, force_ack;
    int sort_cnt, sort_cyc, lo_cnt, hi_cnt, exp_plane;
    int done_cnt, done_cyc, data_err, addr_err, idx_err, hold_err, strobe_err;
    logic        prev_req, prev_ack;
    logic [11:0] prev_addr, first_lo_addr, first_hi_addr;
    logic [7:0]  exp_d1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_stats();
        cyc = 0; wait_cnt = 0; force_ack = 0;
        sort_cnt = 0; sort_cyc = -1; lo_cnt = 0; hi_cnt = 0; exp_plane = 0;
        done_cnt = 0; done_cyc = -1; data_err = 0; addr_err = 0; idx_err = 0;
        hold_err = 0; strobe_err = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
        first_lo_addr = 12'hFFF; first_hi_addr = 12'hFFF;
    endtask

    // One clock: clear pulses, observe outputs, then play the VRAM and sprite engine.
    task automatic tick();
        logic [10:0] exp_a;
        @(posedge clk);
        #1;
        cyc++;
        line_start = 1'b0;
        abort      = 1'b0;
        addr = (addr_mode != 0) ? {3'b000, index, 4'b0000} : 11'h155;
        if (sort) begin
            sort_cnt++;
            if (sort_cyc < 0) sort_cyc = cyc;
        end
        if (vram_req) begin
            exp_a = (addr_mode != 0) ? 11'(hi_cnt * 16) : 11'h155;
            if (vram_addr !== {exp_a, exp_plane[0]}) addr_err++;
            if (exp_plane == 0 && first_lo_addr == 12'hFFF) first_lo_addr = vram_addr;
            if (exp_plane == 1 && first_hi_addr == 12'hFFF) first_hi_addr = vram_addr;
        end
        if (prev_req && !prev_ack && (!vram_req || vram_addr !== prev_addr)) hold_err++;
        if (vram_req || dvalid != 2'b00) begin
            if (index !== 4'(hi_cnt)) idx_err++;
        end
        if (dvalid == 2'b01 || dvalid == 2'b10) begin
            if (!(prev_req && prev_ack && prev_addr[0] == exp_plane[0])) strobe_err++;
            if (dvalid[1] != exp_plane[0]) strobe_err++;
            exp_d1 = {3'b000, exp_plane[0], 4'(hi_cnt)};
            if (data !== (exp_plane != 0 ? 8'h5A : 8'hA5) || data1 !== exp_d1) data_err++;
            if (exp_plane == 0) begin
                lo_cnt++; exp_plane = 1;
            end else begin
                hi_cnt++; exp_plane = 0;
            end
        end else if (dvalid != 2'b00) begin
            strobe_err++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_req  = vram_req;
        prev_addr = vram_addr;
        if (force_ack != 0) begin
            vram_ack = 1'b1;
        end else if (vram_req) begin
            if (wait_cnt >= ack_delay) vram_ack = 1'b1;
            else begin
                vram_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            vram_ack = 1'b0;
            wait_cnt = 0;
        end
        vram_data  = vram_addr[0] ? 8'h5A : 8'hA5;
        vram_data1 = {3'b000, vram_addr[0], 4'(hi_cnt)};
        prev_ack   = vram_ack;
    endtask

    // Pulse line_start in cycle 0; optionally pulse it again (new cycle 0) at restart_at.
    task automatic run_line(input int delay, input int mode, input int restart_at, input int budget);
        clear_stats();
        ack_delay = delay;
        addr_mode = mode;
        line_start = 1'b1;
        while (done_cnt == 0 && cyc < budget) begin
            tick();
            if (restart_at > 0 && cyc == restart_at) begin
                restart_at = 0;
                line_start = 1'b1;
                cyc = 0;
            end
        end
    endtask

    logic found;

    initial begin
        ack_delay = 0; addr_mode = 0;
        clear_stats();
        reset = 1'b1;
        repeat (3) tick();
        check("reset_outputs", {sort, index, vram_req, vram_addr, dvalid, data, data1, busy, done}, 32'h0);
        reset = 1'b0;
        tick();

        run_line(0, 0, 0, 300);
        check("zw_sort_cycle", sort_cyc, 1);
        check("zw_first_lo_addr", first_lo_addr, 12'h2AA);
        check("zw_first_hi_addr", first_hi_addr, 12'h2AB);
        check("zw_lo_strobes", lo_cnt, 10);
        check("zw_hi_strobes", hi_cnt, 10);
        check("zw_data", data_err, 0);
        check("zw_strobe_timing", strobe_err, 0);
        check("zw_done_cycle", done_cyc, 91);
        check("zw_busy_at_done", busy, 0);
        tick();
        check("zw_done_single", {done, busy}, 2'b00);

        run_line(3, 0, 0, 400);
        check("ws_done_cycle", done_cyc, 151);
        check("ws_req_hold", hold_err, 0);
        check("ws_data", data_err, 0);
        check("ws_strobe_timing", strobe_err, 0);
        tick();

        run_line(0, 1, 0, 300);
        check("idx_stable", idx_err, 0);
        check("idx_addr_track", addr_err, 0);
        check("idx_done_cycle", done_cyc, 91);
        tick();

        clear_stats();
        ack_delay = 2; addr_mode = 0;
        line_start = 1'b1;
        found = 1'b0;
        while (!found && cyc < 300) begin
            tick();
            if (hi_cnt == 4 && exp_plane == 1 && vram_req) found = 1'b1;
        end
        check("ab_reach_req_hi", found, 1'b1);
        abort = 1'b1;
        tick();
        check("ab_vram_req", vram_req, 0);
        check("ab_busy", busy, 0);
        check("ab_dvalid", dvalid, 2'b00);
        check("ab_sort", sort, 0);
        force_ack = 1;
        repeat (5) tick();
        force_ack = 0;
        repeat (100) tick();
        check("ab_no_done", done_cnt, 0);
        check("ab_ack_ignored", {lo_cnt, hi_cnt}, {32'd5, 32'd4});
        check("ab_idle_req", {vram_req, busy}, 2'b00);

        run_line(0, 0, 20, 300);
        check("rs_sort_pulses", sort_cnt, 2);
        check("rs_done_cycle", done_cyc, 91);
        tick();

        clear_stats();
        line_start = 1'b1;
        abort = 1'b1;
        tick();
        check("col_idle_sort", {sort, busy}, 2'b00);
        line_start = 1'b1;
        repeat (10) tick();
        abort = 1'b1;
        line_start = 1'b1;
        tick();
        check("col_busy_abort", {sort, busy}, 2'b00);
        repeat (100) tick();
        check("col_no_done", done_cnt, 0);
        check("col_sort_count", sort_cnt, 1);

        clear_stats();
        ack_delay = 0;
        line_start = 1'b1;
        found = 1'b0;
        while (!found && cyc < 300) begin
            tick();
            if (dvalid == 2'b01 && hi_cnt == 2) found = 1'b1;
        end
        check("rst_reach_dv_lo", found, 1'b1);
        reset = 1'b1;
        tick();
        check("rst_outputs", {sort, index, vram_req, vram_addr, dvalid, data, data1, busy, done}, 32'h0);
        reset = 1'b0;
        tick();
        check("rst_stays_idle", {busy, vram_req}, 2'b00);
        run_line(0, 0, 0, 300);
        check("rst_relaunch_done", done_cyc, 91);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
